ntt_cmd_sequencer: RTL and testbench

Host-side initiator for the NTT core command/data port. It drives the core's OP_CODE / din_valid / din0 inputs and observes its done output. It takes a queue of commands (opcode, word count, mode, wait flag) and a 32-bit source word stream. For each command it generates the exact pulse and burst framing the core expects: 1-cycle opcode pulse, data burst, 1-cycle idle gap, optional wait for done.

---
 rtl/ntt_cmd_sequencer_if.sv | 34 +++
 rtl/ntt_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_ntt_cmd_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_cmd_sequencer_if.sv
// rtl/ntt_cmd_sequencer_if.sv - command, source and core-port bundle for the NTT command sequencer
interface ntt_cmd_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_strobe;
  logic              cmd_wait;
  logic              src_valid;
  logic              src_ready;
  logic [DATA_W-1:0] src_data;
  logic [4:0]        OP_CODE;
  logic              din_valid;
  logic [DATA_W-1:0] din0;
  logic              done;
  logic              busy;
  logic              err;

  // master is the sequencer; slave is the command queue, word source and core around it
  modport master (
    input  cmd_valid, cmd_op, cmd_len, cmd_strobe, cmd_wait,
    input  src_valid, src_data, done,
    output cmd_ready, src_ready, OP_CODE, din_valid, din0, busy, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_len, cmd_strobe, cmd_wait,
    output src_valid, src_data, done,
    input  cmd_ready, src_ready, OP_CODE, din_valid, din0, busy, err
  );
endinterface

// File: rtl/ntt_cmd_sequencer.sv
// rtl/ntt_cmd_sequencer.sv - frames queued commands into opcode pulse, data burst, gap and done wait
module ntt_cmd_sequencer #(
  parameter int                   DATA_W    = 32,
  parameter int                   LEN_W     = 16,
  parameter int                   TIMEOUT_W = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 20'hFFFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  ntt_cmd_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_STREAM,
    ST_GAP,
    ST_WAIT
  } state_t;

  localparam logic [LEN_W-1:0]     CNT_ONE   = LEN_W'(1);
  localparam logic [TIMEOUT_W-1:0] WCNT_LAST = TIMEOUT - TIMEOUT_W'(1);

  state_t               state_q, state_d;
  logic [4:0]           op_code_q, op_code_d;
  logic                 din_valid_q, din_valid_d;
  logic [DATA_W-1:0]    din0_q, din0_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] wcnt_q, wcnt_d;
  logic                 err_q, err_d;
  logic                 strobe_q, strobe_d;
  logic                 wait_q, wait_d;
  logic                 src_take;

  // Handshakes are gated by reset so nothing is accepted on an edge that discards it
  assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
  assign bus.src_ready = (state_q == ST_STREAM) && !strobe_q && !reset;
  assign src_take      = bus.src_ready && bus.src_valid;

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.OP_CODE   = op_code_q;
  assign bus.din_valid = din_valid_q;
  assign bus.din0      = din0_q;
  assign bus.err       = err_q;

  always_comb begin
    state_d     = state_q;
    op_code_d   = op_code_q;
    din_valid_d = din_valid_q;
    din0_d      = din0_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    strobe_d    = strobe_q;
    wait_d      = wait_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d     = ST_OPC;
          op_code_d   = bus.cmd_op;
          din_valid_d = bus.cmd_strobe;
          cnt_d       = bus.cmd_len;
          err_d       = 1'b0;
          strobe_d    = bus.cmd_strobe;
          wait_d      = bus.cmd_wait;
          if (bus.cmd_strobe) begin
            din0_d = '0;
          end
        end
      end

      ST_OPC: begin
        op_code_d = '0;
        if (cnt_q == '0) begin
          din_valid_d = 1'b0;
          state_d     = ST_GAP;
        end else begin
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (strobe_q) begin
          // Final decrement drops din_valid so it spans exactly OPC plus len cycles
          din0_d = '0;
          cnt_d  = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            din_valid_d = 1'b0;
            state_d     = ST_GAP;
          end else begin
            din_valid_d = 1'b1;
          end
        end else if (src_take) begin
          din0_d      = bus.src_data;
          din_valid_d = 1'b1;
          cnt_d       = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_GAP;
          end
        end else begin
          din_valid_d = 1'b0;
        end
      end

      ST_GAP: begin
        din_valid_d = 1'b0;
        op_code_d   = '0;
        wcnt_d      = '0;
        state_d     = wait_q ? ST_WAIT : ST_IDLE;
      end

      ST_WAIT: begin
        if (bus.done) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == WCNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + TIMEOUT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_code_q   <= '0;
      din_valid_q <= 1'b0;
      din0_q      <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      strobe_q    <= 1'b0;
      wait_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_code_q   <= op_code_d;
      din_valid_q <= din_valid_d;
      din0_q      <= din0_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      strobe_q    <= strobe_d;
      wait_q      <= wait_d;
    end
  end

endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// tb/tb_ntt_cmd_sequencer.sv - directed self-checking bench for ntt_cmd_sequencer
module tb_ntt_cmd_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   tcyc   = 0;

  always #5 clk = ~clk;

  ntt_cmd_sequencer_if #(.DATA_W(32), .LEN_W(16)) bus ();

  ntt_cmd_sequencer #(
    .DATA_W(32),
    .LEN_W(16),
    .TIMEOUT_W(20),
    .TIMEOUT(20'd16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] src_mem [0:4095];
  logic [31:0] obs_q [$];
  int          src_idx, op_cycles, dv_count, dv_first, dv_last, dv_model_err, idle_cyc, nz_valid;
  logic [4:0]  op_first;
  logic        sr_seen;

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic send_cmd(input logic [4:0] op, input int len, input logic strobe, input logic wt);
    int n = 0;
    bus.cmd_op     = op;
    bus.cmd_len    = 16'(len);
    bus.cmd_strobe = strobe;
    bus.cmd_wait   = wt;
    bus.cmd_valid  = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", bus.cmd_ready);
    end
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Called in the opcode cycle; plays the source and core until busy drops, budget ends or stop_words are handed over
  task automatic run_burst(input logic strobe, input logic throttle, input int done_at, input logic done_hold,
                           input int stop_words, input int budget);
    int   cyc = 0;
    logic exp_dv = 1'b0;
    obs_q.delete();
    src_idx = 0; op_cycles = 0; dv_count = 0; dv_first = -1; dv_last = -1;
    dv_model_err = 0; idle_cyc = -1; nz_valid = 0; sr_seen = 1'b0;
    op_first = bus.OP_CODE;
    while (cyc < budget) begin
      if (bus.OP_CODE !== 5'd0) op_cycles++;
      if (bus.din_valid === 1'b1) begin
        obs_q.push_back(bus.din0);
        dv_count++;
        if (dv_first < 0) dv_first = cyc;
        dv_last = cyc;
        if (bus.din0 !== 32'd0) nz_valid++;
      end
      if (!strobe && bus.din_valid !== exp_dv) dv_model_err++;
      if (bus.src_ready === 1'b1) sr_seen = 1'b1;
      if (bus.busy === 1'b0) begin
        idle_cyc = cyc;
        break;
      end
      bus.src_valid = throttle ? ((cyc % 2) == 1) : 1'b1;
      bus.src_data  = src_mem[src_idx % 4096];
      bus.done      = (done_at >= 0) && (done_hold ? (cyc >= done_at) : (cyc == done_at));
      exp_dv        = bus.src_valid && bus.src_ready;
      if (exp_dv) src_idx++;
      tick();
      cyc++;
      if (stop_words > 0 && src_idx == stop_words) break;
    end
    bus.src_valid = 1'b0;
    bus.done      = 1'b0;
  endtask

  function automatic int obs_bad(input int n);
    int bad = 0;
    if (obs_q.size() != n) bad++;
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      if (obs_q[i] !== src_mem[i]) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 5'd0; bus.cmd_len = 16'd0; bus.cmd_strobe = 1'b0; bus.cmd_wait = 1'b0;
    bus.src_valid = 1'b0; bus.src_data = 32'd0; bus.done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready); end
    checks++; if (bus.src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready: got %b required 0", bus.src_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.OP_CODE !== 5'd0) begin errors++; $display("FAIL reset_op_code: got %0h required 0", bus.OP_CODE); end
    checks++; if (bus.din_valid !== 1'b0 || bus.din0 !== 32'd0) begin errors++; $display("FAIL reset_din: got valid=%b din0=%0h required 0/0", bus.din_valid, bus.din0); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", bus.err); end
  endtask

  task automatic test_param_load();
    src_mem[0] = 32'd2; src_mem[1] = 32'd12289; src_mem[2] = 32'd12277;
    send_cmd(5'b00001, 3, 1'b0, 1'b0);
    run_burst(1'b0, 1'b0, -1, 1'b0, 0, 64);
    checks++; if (op_first !== 5'd1 || op_cycles != 1) begin errors++; $display("FAIL param_opcode: got op=%0h cycles=%0d required 1/1", op_first, op_cycles); end
    checks++; if (dv_count != 3 || dv_first != 2 || dv_last != 4) begin errors++; $display("FAIL param_din_valid: got n=%0d first=%0d last=%0d required 3/2/4", dv_count, dv_first, dv_last); end
    checks++; if (obs_bad(3) != 0) begin errors++; $display("FAIL param_words: got %0d bad words required 0", obs_bad(3)); end
    checks++; if (idle_cyc != 5 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL param_idle: got idle_cyc=%0d cmd_ready=%b required 5/1", idle_cyc, bus.cmd_ready); end
    checks++; if (src_idx != 3 || dv_model_err != 0) begin errors++; $display("FAIL param_consume: got taken=%0d dv_err=%0d required 3/0", src_idx, dv_model_err); end
  endtask

  task automatic test_back_to_back();
    int t0;
    for (int i = 0; i < 4; i++) src_mem[i] = 32'hB000_0000 + 32'(i);
    send_cmd(5'b00010, 4, 1'b0, 1'b0);
    t0 = tcyc;
    run_burst(1'b0, 1'b0, -1, 1'b0, 0, 64);
    checks++; if (dv_count != 4 || obs_bad(4) != 0) begin errors++; $display("FAIL b2b_first_burst: got n=%0d bad=%0d required 4/0", dv_count, obs_bad(4)); end
    send_cmd(5'b00011, 0, 1'b0, 1'b0);
    checks++; if (tcyc - t0 != 7 || bus.OP_CODE !== 5'd3) begin errors++; $display("FAIL b2b_spacing: got %0d cycles op=%0h required 7/3", tcyc - t0, bus.OP_CODE); end
    run_burst(1'b0, 1'b0, -1, 1'b0, 0, 64);
    checks++; if (idle_cyc != 2 || dv_count != 0 || src_idx != 0) begin errors++; $display("FAIL b2b_len0: got idle=%0d n=%0d taken=%0d required 2/0/0", idle_cyc, dv_count, src_idx); end
  endtask

  task automatic test_throttled();
    for (int i = 0; i < 2552; i++) src_mem[i] = (32'(i) * 32'h9E37_79B1) + 32'h0000_1234;
    send_cmd(5'b00010, 2552, 1'b0, 1'b0);
    run_burst(1'b0, 1'b1, -1, 1'b0, 0, 6000);
    checks++; if (dv_count != 2552) begin errors++; $display("FAIL throttle_count: got %0d required 2552", dv_count); end
    checks++; if (dv_model_err != 0) begin errors++; $display("FAIL throttle_bubbles: got %0d misplaced din_valid required 0", dv_model_err); end
    checks++; if (obs_bad(2552) != 0) begin errors++; $display("FAIL throttle_words: got %0d bad words required 0", obs_bad(2552)); end
    checks++; if (idle_cyc != 5105 || src_idx != 2552) begin errors++; $display("FAIL throttle_end: got idle=%0d taken=%0d required 5105/2552", idle_cyc, src_idx); end
  endtask

  task automatic test_read_strobe();
    send_cmd(5'b01011, 137, 1'b1, 1'b0);
    run_burst(1'b1, 1'b0, -1, 1'b0, 0, 400);
    checks++; if (op_first !== 5'b01011 || op_cycles != 1) begin errors++; $display("FAIL strobe_opcode: got op=%0h cycles=%0d required b/1", op_first, op_cycles); end
    checks++; if (dv_count != 138 || dv_first != 0 || dv_last != 137) begin errors++; $display("FAIL strobe_span: got n=%0d first=%0d last=%0d required 138/0/137", dv_count, dv_first, dv_last); end
    checks++; if (sr_seen !== 1'b0 || src_idx != 0) begin errors++; $display("FAIL strobe_src_ready: got seen=%b taken=%0d required 0/0", sr_seen, src_idx); end
    checks++; if (nz_valid != 0) begin errors++; $display("FAIL strobe_din0: got %0d nonzero words required 0", nz_valid); end
    checks++; if (idle_cyc != 139) begin errors++; $display("FAIL strobe_idle: got %0d required 139", idle_cyc); end
  endtask

  task automatic test_wait_done();
    send_cmd(5'b00100, 0, 1'b0, 1'b1);
    run_burst(1'b0, 1'b0, 10, 1'b1, 0, 100);
    checks++; if (op_first !== 5'd4 || op_cycles != 1) begin errors++; $display("FAIL wait_opcode: got op=%0h cycles=%0d required 4/1", op_first, op_cycles); end
    checks++; if (idle_cyc != 11 || bus.cmd_ready !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL wait_done: got idle=%0d ready=%b err=%b required 11/1/0", idle_cyc, bus.cmd_ready, bus.err); end
    send_cmd(5'b00100, 0, 1'b0, 1'b1);
    run_burst(1'b0, 1'b0, 17, 1'b1, 0, 100);
    checks++; if (idle_cyc != 18 || bus.err !== 1'b0) begin errors++; $display("FAIL wait_done_last_cycle: got idle=%0d err=%b required 18/0", idle_cyc, bus.err); end
  endtask

  task automatic test_timeout();
    send_cmd(5'b00100, 0, 1'b0, 1'b1);
    run_burst(1'b0, 1'b0, -1, 1'b0, 0, 100);
    checks++; if (idle_cyc != 18 || bus.err !== 1'b1) begin errors++; $display("FAIL timeout_err: got idle=%0d err=%b required 18/1", idle_cyc, bus.err); end
    repeat (2) tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b required 1", bus.err); end
    send_cmd(5'b00100, 0, 1'b0, 1'b1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b required 0", bus.err); end
    run_burst(1'b0, 1'b0, 1, 1'b0, 0, 100);
    checks++; if (idle_cyc != 18 || bus.err !== 1'b1) begin errors++; $display("FAIL gap_done_ignored: got idle=%0d err=%b required 18/1", idle_cyc, bus.err); end
    send_cmd(5'b00001, 0, 1'b0, 1'b0);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL timeout_clear2: got %b required 0", bus.err); end
    run_burst(1'b0, 1'b0, -1, 1'b0, 0, 64);
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 2048; i++) src_mem[i] = 32'hD000_0000 + 32'(i);
    send_cmd(5'b00011, 2048, 1'b0, 1'b0);
    run_burst(1'b0, 1'b0, -1, 1'b0, 10, 100);
    checks++; if (src_idx != 10 || dv_count != 9 || obs_bad(9) != 0) begin errors++; $display("FAIL abort_prefix: got taken=%0d n=%0d bad=%0d required 10/9/0", src_idx, dv_count, obs_bad(9)); end
    reset = 1'b1;
    bus.src_valid = 1'b1;
    #1;
    checks++; if (bus.src_ready !== 1'b0) begin errors++; $display("FAIL abort_src_ready_in_reset: got %b required 0", bus.src_ready); end
    tick();
    reset = 1'b0;
    bus.src_valid = 1'b0;
    #1;
    checks++; if (bus.OP_CODE !== 5'd0 || bus.din_valid !== 1'b0) begin errors++; $display("FAIL abort_core_idle: got op=%0h valid=%b required 0/0", bus.OP_CODE, bus.din_valid); end
    checks++; if (bus.busy !== 1'b0 || bus.src_ready !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_state: got busy=%b src_ready=%b cmd_ready=%b required 0/0/1", bus.busy, bus.src_ready, bus.cmd_ready); end
    for (int i = 0; i < 2048; i++) src_mem[i] = 32'hE000_0000 ^ (32'(i) << 3);
    send_cmd(5'b00011, 2048, 1'b0, 1'b0);
    run_burst(1'b0, 1'b0, -1, 1'b0, 0, 3000);
    checks++; if (dv_count != 2048 || obs_bad(2048) != 0) begin errors++; $display("FAIL rerun_burst: got n=%0d bad=%0d required 2048/0", dv_count, obs_bad(2048)); end
    checks++; if (idle_cyc != 2050 || src_idx != 2048) begin errors++; $display("FAIL rerun_end: got idle=%0d taken=%0d required 2050/2048", idle_cyc, src_idx); end
  endtask

  initial begin
    test_reset();
    test_param_load();
    test_back_to_back();
    test_throttled();
    test_read_strobe();
    test_wait_done();
    test_timeout();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
